// File: rtl/test_card_checker_pkg.sv
// Shared constants and types for the border test card generator and checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test_card_checker_pkg;

  // Default border width of the simple test card, in pixels.
  localparam int BW_DEFAULT = 16;

  // Sync polarity encodings used by the standard video modes.
  localparam bit VPOL_ACTIVE_LOW  = 1'b0;
  localparam bit VPOL_ACTIVE_HIGH = 1'b1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/test_card_simple.sv
// Simple border test card: colour of pixel (x, y) from its position alone.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the coordinates every cycle.
// Ports: i_x/i_y pixel coordinates; o_red/o_green/o_blue expected colour.
module test_card_simple
  import test_card_checker_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int BW    = BW_DEFAULT
) (
  input  logic [15:0] i_x,
  input  logic [15:0] i_y,
  output logic [7:0]  o_red,
  output logic [7:0]  o_green,
  output logic [7:0]  o_blue
);

  localparam logic [15:0] BW_W  = 16'(BW);
  localparam logic [15:0] BTM_W = 16'(V_RES - BW);
  localparam logic [15:0] RGT_W = 16'(H_RES - BW);

  logic top, btm, lft, rgt;

  assign top = (i_y < BW_W);
  assign btm = (i_y >= BTM_W);
  assign lft = (i_x < BW_W);
  assign rgt = (i_x >= RGT_W);

  // Top band is white; the other edges each light a single channel.
  assign o_red   = {8{lft | top}};
  assign o_green = {8{btm | top}};
  assign o_blue  = {8{rgt | top}};

endmodule

// File: rtl/test_card_checker.sv
// Sink-side checker: rebuilds x/y from DE and compares each active pixel to the test card.
// Latency: frame edge at the input in cycle N reports (o_frame_done) in cycle N+2.
// Backpressure: none; consumes one pixel per clock, the stream cannot be stalled.
// Ports: i_pix_clk/i_rst clock and sync reset; i_vs/i_de/i_red/i_green/i_blue video in;
//        o_locked, o_frame_done, o_frame_pass, o_err_count, o_frame_count per-frame report.
module test_card_checker
  import test_card_checker_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int BW    = BW_DEFAULT,
  parameter bit V_POL = VPOL_ACTIVE_LOW
) (
  input  logic        i_pix_clk,
  input  logic        i_rst,
  input  logic        i_vs,
  input  logic        i_de,
  input  logic [7:0]  i_red,
  input  logic [7:0]  i_green,
  input  logic [7:0]  i_blue,
  output logic        o_locked,
  output logic        o_frame_done,
  output logic        o_frame_pass,
  output logic [15:0] o_err_count,
  output logic [15:0] o_frame_count
);

  localparam logic [15:0] H_END = 16'(H_RES);
  localparam logic [15:0] V_END = 16'(V_RES);

  state_t      state, state_nx;
  logic        vs_q, vs_qq, de_q, de_qq;
  rgb_t        pix_q;
  logic [7:0]  exp_r, exp_g, exp_b;
  logic [15:0] x_q, y_q, err_q, err_nx, y_end;
  logic        geom_q, geom_nx, frame_geom;
  logic        frame_edge, de_fall, in_range, pix_bad;
  logic        clr, chk, report;

  // Stage 1: register the raw stream. vs history resets high so that a
  // reset released in the middle of a sync pulse cannot fake a frame edge.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      vs_q  <= 1'b1;
      vs_qq <= 1'b1;
      de_q  <= 1'b0;
      de_qq <= 1'b0;
      pix_q <= '0;
    end else begin
      vs_q  <= i_vs ~^ V_POL;
      vs_qq <= vs_q;
      de_q  <= i_de;
      de_qq <= de_q;
      pix_q <= '{r: i_red, g: i_green, b: i_blue};
    end
  end

  assign frame_edge = vs_q & ~vs_qq;
  assign de_fall    = de_qq & ~de_q;

  test_card_simple #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .BW    (BW)
  ) u_golden (
    .i_x     (x_q),
    .i_y     (y_q),
    .o_red   (exp_r),
    .o_green (exp_g),
    .o_blue  (exp_b)
  );

  // Stage 2 compare. Out-of-range pixels are geometry faults, not colour faults.
  assign in_range   = (x_q < H_END) && (y_q < V_END);
  assign pix_bad    = de_q && in_range && (pix_q != {exp_r, exp_g, exp_b});
  assign err_nx     = pix_bad ? sat_inc16(err_q) : err_q;
  assign geom_nx    = geom_q | (de_q & ~in_range) | (de_fall & (x_q != H_END));
  // A line ending in the same cycle as the frame edge still counts toward y.
  assign y_end      = de_fall ? sat_inc16(y_q) : y_q;
  assign frame_geom = (y_end != V_END);

  // FSM: state register.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // FSM: next state.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (frame_edge) state_nx = ST_ARMED;
      ST_ARMED:  if (!frame_edge && de_q) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (frame_edge) state_nx = ST_ARMED;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // FSM: controls. The first DE cycle in ARMED is pixel (0,0) and is
  // checked directly, since ARMED keeps the counters at zero.
  always_comb begin
    clr    = 1'b0;
    chk    = 1'b0;
    report = 1'b0;
    case (state)
      ST_IDLE: clr = 1'b1;
      ST_ARMED: begin
        if (!frame_edge && de_q) chk = 1'b1;
        else                     clr = 1'b1;
      end
      ST_ACTIVE: begin
        if (frame_edge) begin
          report = 1'b1;
          clr    = 1'b1;
        end else begin
          chk = 1'b1;
        end
      end
      default: clr = 1'b1;
    endcase
  end

  // Position counters and per-frame accumulators.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst || clr) begin
      x_q    <= '0;
      y_q    <= '0;
      err_q  <= '0;
      geom_q <= 1'b0;
    end else if (chk) begin
      err_q  <= err_nx;
      geom_q <= geom_nx;
      if (de_q) begin
        x_q <= sat_inc16(x_q);
      end else if (de_fall) begin
        x_q <= '0;
        y_q <= y_end;
      end
    end
  end

  // Report registers; the report folds in this cycle's pixel and line-end checks.
  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      o_locked      <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_pass  <= 1'b0;
      o_err_count   <= '0;
      o_frame_count <= '0;
    end else begin
      o_frame_done <= report;
      if (report) begin
        o_locked      <= 1'b1;
        o_err_count   <= err_nx;
        o_frame_pass  <= (err_nx == 16'd0) && !geom_nx && !frame_geom;
        o_frame_count <= o_frame_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_test_card_checker.sv
module tb_test_card_checker;

  localparam int K_CLEAN   = 0;
  localparam int K_CORRUPT = 1;
  localparam int K_INVERT  = 2;

  typedef struct {
    int          kind;
    int          short_line;
    int          lines;
    int          rst_line;
    int          exp_n;
    bit          exp_pass;
    logic [15:0] exp_err;
    logic [15:0] exp_cnt;
    bit          exp_lock;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        vs_in, vs1_in, de_in;
  logic [7:0]  red, green, blue;
  logic        lock0, done0, pass0, lock1, done1, pass1;
  logic [15:0] err0, cnt0, err1, cnt1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int edge_cyc = 0;
  int wide = 0;
  logic vs_prev = 1'b0;
  logic prev_done0 = 1'b0;
  logic prev_done1 = 1'b0;

  int          rep_n, rep_dly, rep1_n;
  logic        rep_pass, rep_lock, rep1_pass;
  logic [15:0] rep_err, rep_cnt, rep1_err, rep1_cnt;

  vec_t tbl[16];

  always #5 clk = ~clk;

  // V_POL=1 instance sees the same stream with vs inverted.
  assign vs1_in = ~vs_in;

  test_card_checker #(.H_RES(32), .V_RES(24), .BW(4), .V_POL(1'b0)) dut0 (
    .i_pix_clk(clk), .i_rst(rst0), .i_vs(vs_in), .i_de(de_in),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_locked(lock0), .o_frame_done(done0), .o_frame_pass(pass0),
    .o_err_count(err0), .o_frame_count(cnt0)
  );

  test_card_checker #(.H_RES(32), .V_RES(24), .BW(4), .V_POL(1'b1)) dut1 (
    .i_pix_clk(clk), .i_rst(rst1), .i_vs(vs1_in), .i_de(de_in),
    .i_red(red), .i_green(green), .i_blue(blue),
    .o_locked(lock1), .o_frame_done(done1), .o_frame_pass(pass1),
    .o_err_count(err1), .o_frame_count(cnt1)
  );

  function automatic logic [23:0] exp_pix(input int x, input int y);
    logic t, b, l, r;
    t = (y < 4);
    b = (y >= 20);
    l = (x < 4);
    r = (x >= 28);
    return {{8{l | t}}, {8{b | t}}, {8{r | t}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One pixel clock: sample outputs at the falling edge, then drive the next inputs.
  task automatic tick(input logic vs_act, input logic de, input logic [23:0] rgb);
    @(negedge clk);
    cyc++;
    if (done0) begin
      rep_n++;
      rep_pass = pass0;
      rep_err  = err0;
      rep_cnt  = cnt0;
      rep_lock = lock0;
      rep_dly  = cyc - edge_cyc;
      if (prev_done0) wide++;
    end
    if (done1) begin
      rep1_n++;
      rep1_pass = pass1;
      rep1_err  = err1;
      rep1_cnt  = cnt1;
      if (prev_done1) wide++;
    end
    prev_done0 = done0;
    prev_done1 = done1;
    if (vs_act && !vs_prev) edge_cyc = cyc;
    vs_prev = vs_act;
    vs_in = ~vs_act;
    de_in = de;
    // Blanking carries junk colour, which must be ignored.
    red   = de ? rgb[23:16] : 8'($urandom);
    green = de ? rgb[15:8]  : 8'($urandom);
    blue  = de ? rgb[7:0]   : 8'($urandom);
  endtask

  // 48x30 raster, 32x24 active (unless altered), vsync on lines 26-27.
  task automatic run_frame(input vec_t v);
    logic [23:0] px;
    logic        d;
    rep_n = 0;
    rep1_n = 0;
    for (int y = 0; y < 30; y++) begin
      for (int x = 0; x < 48; x++) begin
        d  = (x < ((y == v.short_line) ? 31 : 32)) && (y < v.lines);
        px = exp_pix(x, y);
        if (v.kind == K_CORRUPT && x == 5 && y == 10) px = 24'hFFFFFF;
        if (v.kind == K_CORRUPT && x == 31 && y == 0) px = 24'h000000;
        if (v.kind == K_INVERT) px = ~px;
        if (v.kind == K_INVERT && y == 1 && x == 0) force dut0.err_q = 16'hFFFF;
        if (v.kind == K_INVERT && y == 1 && x == 1) release dut0.err_q;
        rst0 = (y == v.rst_line && x == 0);
        tick(y == 26 || y == 27, d, px);
      end
    end
  endtask

  initial begin
    //          kind       short lines rst  n  pass err       cnt     lock
    tbl[0]  = '{K_CLEAN,   -1,   24,   -1,  0, 0,   16'h0,    16'd0,  0};
    tbl[1]  = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd1,  1};
    tbl[2]  = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd2,  1};
    tbl[3]  = '{K_CORRUPT, -1,   24,   -1,  1, 0,   16'h2,    16'd3,  1};
    tbl[4]  = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd4,  1};
    tbl[5]  = '{K_CLEAN,    7,   24,   -1,  1, 0,   16'h0,    16'd5,  1};
    tbl[6]  = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd6,  1};
    tbl[7]  = '{K_CLEAN,   -1,   25,   -1,  1, 0,   16'h0,    16'd7,  1};
    tbl[8]  = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd8,  1};
    tbl[9]  = '{K_INVERT,  -1,   24,   -1,  1, 0,   16'hFFFF, 16'd9,  1};
    tbl[10] = '{K_INVERT,  -1,   24,   -1,  1, 0,   16'hFFFF, 16'd10, 1};
    tbl[11] = '{K_INVERT,  -1,   24,   -1,  1, 0,   16'hFFFF, 16'd11, 1};
    tbl[12] = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd12, 1};
    tbl[13] = '{K_CLEAN,   -1,   24,   12,  0, 0,   16'h0,    16'd0,  0};
    tbl[14] = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd1,  1};
    tbl[15] = '{K_CLEAN,   -1,   24,   -1,  1, 1,   16'h0,    16'd2,  1};

    rst0 = 1'b1;
    rst1 = 1'b1;
    vs_in = 1'b1;
    de_in = 1'b0;
    red = 8'h0;
    green = 8'h0;
    blue = 8'h0;

    // Reset state of both instances.
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 24'h0);
    check("rst_locked",  {31'b0, lock0}, 32'h0);
    check("rst_done",    {31'b0, done0}, 32'h0);
    check("rst_pass",    {31'b0, pass0}, 32'h0);
    check("rst_err",     {16'b0, err0},  32'h0);
    check("rst_count",   {16'b0, cnt0},  32'h0);
    check("rst1_all",    {lock1, done1, pass1, err1, cnt1}, 35'h0);
    rst0 = 1'b0;
    rst1 = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 24'h0);

    for (int i = 0; i < 16; i++) begin
      run_frame(tbl[i]);
      check($sformatf("f%0d reports", i), rep_n, tbl[i].exp_n);
      if (tbl[i].exp_n == 1) begin
        check($sformatf("f%0d pass", i),   {31'b0, rep_pass}, {31'b0, tbl[i].exp_pass});
        check($sformatf("f%0d err", i),    {16'b0, rep_err},  {16'b0, tbl[i].exp_err});
        check($sformatf("f%0d count", i),  {16'b0, rep_cnt},  {16'b0, tbl[i].exp_cnt});
        check($sformatf("f%0d locked", i), {31'b0, rep_lock}, 32'h1);
        check($sformatf("f%0d delay", i),  rep_dly, 2);
      end
      check($sformatf("f%0d end_locked", i), {31'b0, lock0}, {31'b0, tbl[i].exp_lock});
      check($sformatf("f%0d end_count", i),  {16'b0, cnt0},  {16'b0, tbl[i].exp_cnt});
      // Active-high sync instance must agree on the first clean frames.
      if (i < 3) begin
        check($sformatf("vpol1 f%0d reports", i), rep1_n, tbl[i].exp_n);
        if (tbl[i].exp_n == 1) begin
          check($sformatf("vpol1 f%0d pass", i),  {31'b0, rep1_pass}, {31'b0, tbl[i].exp_pass});
          check($sformatf("vpol1 f%0d err", i),   {16'b0, rep1_err},  {16'b0, tbl[i].exp_err});
          check($sformatf("vpol1 f%0d count", i), {16'b0, rep1_cnt},  {16'b0, tbl[i].exp_cnt});
          check($sformatf("vpol1 f%0d locked", i), {31'b0, lock1},    32'h1);
        end
      end
    end

    check("done_pulse_width", wide, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
